ahb_lite_sram_slave: RTL
========================

Name: ahb_lite_sram_slave

Overview:
- Parametrised AHB-Lite (AMBA 3, IHI0033A) slave with internal register-array memory.
- Adds features a plain slave port lacks: configurable wait states, byte/halfword/word sub-word writes with byte lanes, and a two-cycle ERROR response.
- Sits behind the bus decoder as a scratchpad or test memory.
- Pipelined: a new address phase overlaps the current data phase.

Parameters:
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hwdata/hrdata width; one of 32/64.
- MEM_DEPTH, 256, number of DATA_WIDTH words; power of two.
- WAIT_STATES, 0, hreadyout-low cycles inserted per accepted OKAY transfer; 0..15.

Ports:
- hclk  input  1  bus clock; all logic on rising edge.
- hreset  input  1  asynchronous, active-high reset.
- hsel  input  1  slave select from decoder.
- haddr  input  ADDR_WIDTH  byte address.
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hsize  input  3  transfer size, log2 bytes.
- hwrite  input  1  1 = write.
- hprot  input  4  protection attributes.
- hmasterlock  input  1  ignored; accepted for port compatibility.
- hwdata  input  DATA_WIDTH  write data, data phase.
- hready  input  1  bus-level ready from multiplexor.
- hrdata  output  DATA_WIDTH  read data.
- hreadyout  output  1  slave ready.
- hresp  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async, hreset=1): hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, data-phase registers cleared. Memory contents are not reset. Reset mid-transfer abandons it; no write is committed.
- Accept: hsel & hready & htrans[1]. Latches haddr, hsize, hwrite, and the error flag into data-phase registers.
  - IDLE/BUSY or hsel=0: zero-wait OKAY, no access.
- Error condition, evaluated at accept, any one of:
  - haddr >= MEM_DEPTH*DATA_WIDTH/8.
  - hsize > log2(DATA_WIDTH/8).
  - haddr misaligned to hsize.
- FSM states:
  - IDLE: hreadyout=1, hresp=0. Accept OKAY: to WAIT if WAIT_STATES>0, else DATA. Accept error: to ERR1.
  - WAIT: hreadyout=0. Counter loads WAIT_STATES-1 on entry and decrements; counter==0 goes to DATA.
  - DATA: hreadyout=1, hresp=0; final data-phase cycle.
    - Read: hrdata = mem[word index], full word, all lanes; combinational from the registered index.
    - Write: hwdata sampled this cycle; bytes selected by addr low bits and hsize written at the clock edge ending the cycle.
    - Next state: new accept this cycle behaves as from IDLE; otherwise IDLE.
  - ERR1: hreadyout=0, hresp=1; always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1; memory untouched. New accept this cycle behaves as from IDLE.
- hrdata=0 in every cycle except a read DATA cycle.
- Latency: OKAY transfer data phase = WAIT_STATES+1 cycles; ERROR = 2 cycles.
- Read-after-write to the same address, back-to-back with WAIT_STATES=0: the read returns the new data, because the write commits before the read's DATA cycle.
- Master may drive htrans=IDLE during ERR1; no access results. Accept is only possible when hready=1, so ERR1 and WAIT never accept.

Optional Feature:
- Macro: AHB_SLV_PROT_CHECK_EN.
- Defined: a write with hprot[1]=0 (unprivileged) is an error condition, giving the ERR1/ERR2 response with no write. Reads are unaffected.
- Undefined: hprot is ignored entirely.

Decomposition:
- Package ahb_lite_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR localparams.
  - HSIZE_BYTE/HALF/WORD/DWORD localparams.
  - FSM state enum.
  - Function computing the byte-strobe vector from addr low bits and hsize.
- One sub-module: ahb_lite_wstrb_gen, combinational; takes addr low bits and hsize, outputs a DATA_WIDTH/8 strobe.

Test Plan:
- Defaults (WAIT_STATES=0): NONSEQ write 0xDEADBEEF @0x10, then NONSEQ read @0x10 -> read DATA cycle hrdata=0xDEADBEEF, hresp=0, no hreadyout low.
- WAIT_STATES=2: read @0x20 -> hreadyout=0 for exactly 2 cycles, then 1 with data; write @0x20 mid-count not committed until the DATA cycle.
- Byte write 0xAA, hsize=0 @0x13, over word 0x11223344 -> word reads 0xAA223344; halfword write 0x5566 @0x12 -> reads 0x55663344.
- Read @0x400 (MEM_DEPTH=256, 32-bit) -> cycle1 hreadyout=0/hresp=1, cycle2 hreadyout=1/hresp=1. Halfword @0x01 -> same ERROR pattern; memory unchanged.
- Back-to-back NONSEQ/SEQ burst, 4 writes @0x0..0xC then 4 reads -> each beat completes in 1 cycle, correct data. Assert hreset mid-burst during WAIT -> hreadyout=1 immediately, pending write not committed.
- With AHB_SLV_PROT_CHECK_EN, write with hprot=0x1 -> ERROR response, memory unchanged. Same write with hprot=0x3 -> OKAY. Without the macro, hprot=0x1 -> OKAY.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and byte-lane helpers.
// Optional write privilege check is selected by AHB_SLV_PROT_CHECK_EN (see top).
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Strobe for up to 8 lanes; lane is the byte offset inside the bus word.
    function automatic logic [7:0] wstrb_calc(input logic [2:0] lane, input logic [2:0] size);
        logic [7:0] m;
        case (size)
            HSIZE_BYTE: m = 8'h01;
            HSIZE_HALF: m = 8'h03;
            HSIZE_WORD: m = 8'h0F;
            default:    m = 8'hFF;
        endcase
        return m << lane;
    endfunction

    // Low address bits that must be zero for a transfer of the given size.
    function automatic logic [2:0] align_mask(input logic [2:0] size);
        logic [2:0] m;
        case (size)
            HSIZE_BYTE: m = 3'd0;
            HSIZE_HALF: m = 3'd1;
            HSIZE_WORD: m = 3'd3;
            default:    m = 3'd7;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master/decoder side and the SRAM slave.
// Handshake: an address phase is taken when hsel & hready & htrans[1]; a data phase ends on a cycle with hreadyout=1.
interface ahb_lite_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic [2:0]            hsize;
    logic                  hwrite;
    logic [3:0]            hprot;
    logic                  hmasterlock;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;

    modport master (
        output hsel, haddr, htrans, hsize, hwrite, hprot, hmasterlock, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hsize, hwrite, hprot, hmasterlock, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_lite_wstrb_gen.sv
// Byte-lane write strobe from address low bits and hsize.
module ahb_lite_wstrb_gen
    import ahb_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]              addr_lo,
    input  logic [2:0]              size,
    output logic [DATA_WIDTH/8-1:0] strb
);
    localparam int NB = DATA_WIDTH / 8;

    logic [2:0] lane;
    logic [7:0] full;
    logic       unused_strb;

    // Drop address bits above the bus width so lane stays within the word.
    assign lane        = addr_lo & 3'(NB - 1);
    assign full        = wstrb_calc(lane, size);
    assign strb        = full[NB-1:0];
    assign unused_strb = ^full;
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: wait states, byte-lane writes, two-cycle ERROR response.
// Define AHB_SLV_PROT_CHECK_EN to reject unprivileged (hprot[1]=0) writes.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                 hclk,
    input  logic                 hreset,
    ahb_lite_sram_slave_if.slave bus,
    output state_t               state_dbg
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = $clog2(MEM_DEPTH);
    localparam int AQW  = OFFW + IDXW;
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(NB);
    localparam logic [2:0]  SIZE_MAX  = 3'(OFFW);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AQW-1:0]  addr_q;
    logic [2:0]      size_q;
    logic            write_q;
    logic            err_q;

    logic            can_accept;
    logic            accept;
    logic            addr_err, size_err, align_err, prot_err, xfer_err;
    logic            ready;
    logic            resp;
    logic            mem_we;
    logic [NB-1:0]   strb;
    logic [IDXW-1:0] idx;
    logic            unused_sigs;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Only states that drive hreadyout=1 can end a data phase and take a new address.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign accept     = bus.hsel & bus.hready & bus.htrans[1] & can_accept;

    assign addr_err  = ({{(64-ADDR_WIDTH){1'b0}}, bus.haddr} >= MEM_BYTES);
    assign size_err  = (bus.hsize > SIZE_MAX);
    assign align_err = |(bus.haddr[2:0] & align_mask(bus.hsize));
`ifdef AHB_SLV_PROT_CHECK_EN
    assign prot_err  = bus.hwrite & ~bus.hprot[1];
`else
    assign prot_err  = 1'b0;
`endif
    assign xfer_err  = addr_err | size_err | align_err | prot_err;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.haddr[AQW-1:0];
                size_q  <= bus.hsize;
                write_q <= bus.hwrite;
                err_q   <= xfer_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b1;
        resp    = HRESP_OKAY;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                resp    = (state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
                state_d = ST_IDLE;
                if (accept) begin
                    if (xfer_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                ready = 1'b0;
                if (cnt_q == 4'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: begin
                ready   = 1'b0;
                resp    = HRESP_ERROR;
                state_d = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ahb_lite_wstrb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_wstrb (
        .addr_lo (3'(addr_q[OFFW-1:0])),
        .size    (size_q),
        .strb    (strb)
    );

    assign idx    = addr_q[OFFW +: IDXW];
    assign mem_we = (state_q == ST_DATA) & write_q & ~err_q;

    // Write commits at the edge closing the DATA cycle, so a following read sees it.
    always_ff @(posedge hclk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (strb[b]) mem[idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
        end
    end

    assign bus.hrdata    = ((state_q == ST_DATA) && !write_q) ? mem[idx] : '0;
    assign bus.hreadyout = ready;
    assign bus.hresp     = resp;
    assign state_dbg     = state_q;
    assign unused_sigs   = ^{bus.htrans[0], bus.hmasterlock, bus.hprot};
endmodule
